// File: rtl/tis_node_ctrl.sv
// tis_node_ctrl: TIS node execution controller (PC, decode, saturating ALU, blocking stream ports).
// Optional stall counter output enabled by defining TIS_CTRL_STALL_CNT_EN.
module tis_node_ctrl #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned PC_W   = 4,
    parameter int unsigned VMAX   = 999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [PC_W:0]     prog_len,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [21:0]       imem_data,
    input  logic [DATA_W-1:0] acc_val,
    output logic [1:0]        reg_op,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              blocked
`ifdef TIS_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned IMM_W = 11;
    localparam int unsigned AW    = DATA_W + 1;
    localparam int unsigned JW    = DATA_W + 2;

    localparam logic [3:0] OP_MOV = 4'd1, OP_SWP = 4'd2, OP_SAV = 4'd3, OP_ADD = 4'd4,
                           OP_SUB = 4'd5, OP_NEG = 4'd6, OP_JMP = 4'd7, OP_JEZ = 4'd8,
                           OP_JNZ = 4'd9, OP_JGZ = 4'd10, OP_JLZ = 4'd11, OP_JRO = 4'd12;
    localparam logic [2:0] SRC_IMM = 3'd0, SRC_ACC = 3'd1, SRC_IN = 3'd3;
    localparam logic [2:0] DST_ACC = 3'd0, DST_OUT = 3'd2;
    localparam logic [1:0] REG_HOLD = 2'b00, REG_LOAD = 2'b01, REG_SWP = 2'b10, REG_SAV = 2'b11;

    localparam logic signed [AW-1:0]     VMAX_A = AW'(VMAX);
    localparam logic signed [DATA_W-1:0] VMAX_D = DATA_W'(VMAX);

    typedef enum logic {S_RUN, S_WAIT_OUT} state_t;

    state_t              state, state_nxt;
    logic [PC_W-1:0]     pc, pc_nxt;
    logic [DATA_W-1:0]   out_data_nxt;
    logic                out_valid_nxt;

    logic [3:0]               op;
    logic [2:0]               src, dst;
    logic signed [IMM_W-1:0]  imm_s;
    logic signed [DATA_W-1:0] acc_s, src_val;
    logic                     uses_in, unused_rsvd;
    logic [PC_W:0]            len_eff, pc_p1;
    logic [PC_W-1:0]          pc_seq, jmp_tgt, jro_pc;
    logic signed [JW-1:0]     jro_sum, jro_max;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [AW-1:0] v);
        if (v > VMAX_A)       return VMAX_D;
        else if (v < -VMAX_A) return -VMAX_D;
        else                  return DATA_W'(v);
    endfunction

    assign op          = imem_data[21:18];
    assign src         = imem_data[17:15];
    assign dst         = imem_data[14:12];
    assign unused_rsvd = imem_data[11];
    assign imm_s       = $signed(imem_data[IMM_W-1:0]);
    assign acc_s       = $signed(acc_val);
    assign imem_addr   = pc;

    always_comb begin
        src_val = '0;
        case (src)
            SRC_IMM: src_val = DATA_W'(imm_s);
            SRC_ACC: src_val = acc_s;
            SRC_IN:  src_val = $signed(in_data);
            default: src_val = '0;
        endcase
    end

    assign uses_in = (src == SRC_IN) &&
                     (op == OP_MOV || op == OP_ADD || op == OP_SUB || op == OP_JRO);

    // PC targets: sequential wrap, absolute jump (out of range -> 0), clamped relative jump
    assign len_eff = (prog_len == '0) ? (PC_W+1)'(1) : prog_len;
    assign pc_p1   = {1'b0, pc} + (PC_W+1)'(1);
    assign pc_seq  = (pc_p1 >= len_eff) ? '0 : pc_p1[PC_W-1:0];
    assign jmp_tgt = ({1'b0, imem_data[PC_W-1:0]} >= len_eff) ? '0 : imem_data[PC_W-1:0];
    assign jro_sum = $signed(JW'({1'b0, pc})) + JW'(src_val);
    assign jro_max = $signed(JW'(len_eff)) - JW'(1);
    assign jro_pc  = jro_sum[JW-1]       ? '0 :
                     (jro_sum > jro_max) ? PC_W'(jro_max) : PC_W'(jro_sum);

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        reg_op        = REG_HOLD;
        reg_wdata     = '0;
        in_ready      = 1'b0;
        blocked       = 1'b0;
        if (!reset && clk_en) begin
            case (state)
                S_RUN: begin
                    in_ready = uses_in;
                    if (uses_in && !in_valid) begin
                        blocked = 1'b1;
                    end else begin
                        pc_nxt = pc_seq;
                        case (op)
                            OP_MOV: begin
                                if (dst == DST_ACC) begin
                                    reg_op    = REG_LOAD;
                                    reg_wdata = src_val;
                                end else if (dst == DST_OUT) begin
                                    out_data_nxt  = src_val;
                                    out_valid_nxt = 1'b1;
                                    state_nxt     = S_WAIT_OUT;
                                    pc_nxt        = pc;
                                end
                            end
                            OP_SWP: reg_op = REG_SWP;
                            OP_SAV: reg_op = REG_SAV;
                            OP_ADD: begin
                                reg_op    = REG_LOAD;
                                reg_wdata = sat(AW'(acc_s) + AW'(src_val));
                            end
                            OP_SUB: begin
                                reg_op    = REG_LOAD;
                                reg_wdata = sat(AW'(acc_s) - AW'(src_val));
                            end
                            OP_NEG: begin
                                reg_op    = REG_LOAD;
                                reg_wdata = sat(-AW'(acc_s));
                            end
                            OP_JMP: pc_nxt = jmp_tgt;
                            OP_JEZ: if (acc_s == '0) pc_nxt = jmp_tgt;
                            OP_JNZ: if (acc_s != '0) pc_nxt = jmp_tgt;
                            OP_JGZ: if (!acc_s[DATA_W-1] && acc_s != '0) pc_nxt = jmp_tgt;
                            OP_JLZ: if (acc_s[DATA_W-1]) pc_nxt = jmp_tgt;
                            OP_JRO: pc_nxt = jro_pc;
                            default: ;
                        endcase
                    end
                end
                S_WAIT_OUT: begin
                    blocked = !out_ready;
                    if (out_valid && out_ready) begin
                        out_valid_nxt = 1'b0;
                        pc_nxt        = pc_seq;
                        state_nxt     = S_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RUN;
            pc        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
        end
    end

`ifdef TIS_CTRL_STALL_CNT_EN
    // blocked is already gated by clk_en and reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (blocked && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tis_node_ctrl.sv
// Self-checking bench for tis_node_ctrl: register-block model, program ROM, output-stream scoreboard.
module tb_tis_node_ctrl;

    localparam int unsigned DATA_W = 11;
    localparam int unsigned PC_W   = 4;

    localparam logic [3:0] OP_NOP = 4'd0, OP_MOV = 4'd1, OP_SWP = 4'd2, OP_SAV = 4'd3,
                           OP_ADD = 4'd4, OP_SUB = 4'd5, OP_NEG = 4'd6, OP_JMP = 4'd7,
                           OP_JEZ = 4'd8, OP_JNZ = 4'd9, OP_JGZ = 4'd10, OP_JLZ = 4'd11,
                           OP_JRO = 4'd12;
    localparam logic [2:0] S_IMM = 3'd0, S_ACC = 3'd1, S_IN = 3'd3;
    localparam logic [2:0] D_ACC = 3'd0, D_OUT = 3'd2;

    logic                     clk, reset, clk_en;
    logic [PC_W:0]            prog_len;
    logic [PC_W-1:0]          imem_addr;
    logic [21:0]              imem_data;
    logic signed [DATA_W-1:0] acc, bak;
    logic [1:0]               reg_op;
    logic [DATA_W-1:0]        reg_wdata, in_data, out_data;
    logic                     in_valid, in_ready, out_valid, out_ready, blocked;
`ifdef TIS_CTRL_STALL_CNT_EN
    logic [15:0]              stall_cnt;
`endif

    logic [21:0]              imem [16];
    logic signed [DATA_W-1:0] exp_q [$];
    logic signed [DATA_W-1:0] sb_exp;
    int                       n_tests = 0;
    int                       n_fail  = 0;
    int                       exp_pc [7] = '{1, 2, 3, 5, 6, 7, 0};

    tis_node_ctrl #(.DATA_W(DATA_W), .PC_W(PC_W), .VMAX(999)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .prog_len(prog_len),
        .imem_addr(imem_addr), .imem_data(imem_data), .acc_val(acc),
        .reg_op(reg_op), .reg_wdata(reg_wdata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .blocked(blocked)
`ifdef TIS_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    assign imem_data = imem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ACC/BAK register block the controller drives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            bak <= '0;
        end else begin
            case (reg_op)
                2'b01: acc <= $signed(reg_wdata);
                2'b10: begin acc <= bak; bak <= acc; end
                2'b11: bak <= acc;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] enc(input logic [3:0] op, input logic [2:0] src,
                                        input logic [2:0] dst, input logic [10:0] imm);
        return {op, src, dst, 1'b0, imm};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 16; i++) imem[i] = enc(OP_NOP, S_IMM, D_ACC, 11'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output scoreboard: a handshake completes on the next edge
    always @(negedge clk) begin
        if (!reset && clk_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", 1, 0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_out_data", $signed(out_data), sb_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; clk_en = 1'b1; prog_len = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        clear_imem();
        imem[0] = enc(OP_MOV, S_IN, D_ACC, 11'd0);
        prog_len = 5'd1;
        in_valid = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_pc", imem_addr, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_blocked", blocked, 0);
        check("rst_reg_op", reg_op, 0);
        in_valid = 1'b0;

        // Basic MOV/ADD/SUB with wrap and a clk_en pause
        clear_imem();
        imem[0] = enc(OP_MOV, S_IMM, D_ACC, 11'd5);
        imem[1] = enc(OP_ADD, S_IMM, D_ACC, 11'd3);
        imem[2] = enc(OP_SUB, S_IMM, D_ACC, 11'd10);
        prog_len = 5'd3;
        do_reset();
        step(); check("t1_acc0", acc, 5);  check("t1_pc0", imem_addr, 1);
        step(); check("t1_acc1", acc, 8);  check("t1_pc1", imem_addr, 2);
        clk_en = 1'b0;
        #1 check("t1_en0_reg_op", reg_op, 0);
        step(); check("t1_en0_acc", acc, 8); check("t1_en0_pc", imem_addr, 2);
        clk_en = 1'b1;
        step(); check("t1_acc2", acc, -2); check("t1_pc_wrap", imem_addr, 0);

        // Saturation
        clear_imem();
        imem[0] = enc(OP_ADD, S_IMM, D_ACC, 11'd900);
        imem[1] = enc(OP_ADD, S_IMM, D_ACC, 11'd900);
        imem[2] = enc(OP_NEG, S_IMM, D_ACC, 11'd0);
        imem[3] = enc(OP_SUB, S_IMM, D_ACC, 11'd1);
        prog_len = 5'd4;
        do_reset();
        step(); check("t2_add1", acc, 900);
        step(); check("t2_add_sat", acc, 999);
        step(); check("t2_neg", acc, -999);
        step(); check("t2_sub_sat", acc, -999); check("t2_pc_wrap", imem_addr, 0);

        // prog_len = 0 behaves as a single-instruction program
        clear_imem();
        imem[0] = enc(OP_ADD, S_IMM, D_ACC, 11'd1);
        prog_len = 5'd0;
        do_reset();
        step(); check("t2_len0_acc1", acc, 1); check("t2_len0_pc1", imem_addr, 0);
        step(); check("t2_len0_acc2", acc, 2); check("t2_len0_pc2", imem_addr, 0);

        // Input stall then consume
        clear_imem();
        imem[0] = enc(OP_MOV, S_IN, D_ACC, 11'd0);
        prog_len = 5'd2;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_blocked", blocked, 1);
            check("t3_in_ready", in_ready, 1);
            check("t3_reg_op", reg_op, 0);
            step();
            check("t3_pc_held", imem_addr, 0);
        end
        in_data = 11'd42; in_valid = 1'b1;
        #1;
        check("t3_hs", in_ready & in_valid, 1);
        check("t3_unblocked", blocked, 0);
        step(); check("t3_acc", acc, 42); check("t3_pc", imem_addr, 1);
        #1 check("t3_hs_once", in_ready & in_valid, 0);
        in_valid = 1'b0;

        // Output stall then handshake
        clear_imem();
        imem[0] = enc(OP_MOV, S_IMM, D_ACC, 11'd7);
        imem[1] = enc(OP_MOV, S_ACC, D_OUT, 11'd0);
        prog_len = 5'd3;
        out_ready = 1'b0;
        do_reset();
        step(); check("t4_acc", acc, 7);
        exp_q.push_back(11'sd7);
        step(); check("t4_ov", out_valid, 1); check("t4_pc", imem_addr, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_blocked", blocked, 1);
            check("t4_ov_hold", out_valid, 1);
            check("t4_od_hold", $signed(out_data), 7);
            step();
            check("t4_pc_held", imem_addr, 1);
        end
        out_ready = 1'b1;
        #1 check("t4_unblocked", blocked, 0);
        step(); check("t4_ov_clr", out_valid, 0); check("t4_pc_adv", imem_addr, 2);
        check("t4_sb_drained", exp_q.size(), 0);

        // Back-to-back outputs with out_ready held high
        clear_imem();
        imem[0] = enc(OP_MOV, S_IMM, D_OUT, 11'd3);
        imem[1] = enc(OP_MOV, S_IMM, D_OUT, 11'(-4));
        prog_len = 5'd2;
        do_reset();
        exp_q.push_back(11'sd3);
        exp_q.push_back(-11'sd4);
        for (int i = 0; i < 4; i++) step();
        check("t4b_pc", imem_addr, 0); check("t4b_ov", out_valid, 0);
        check("t4b_sb_drained", exp_q.size(), 0);
        out_ready = 1'b0;

        // SAV / conditional jumps / SWP
        clear_imem();
        imem[0] = enc(OP_MOV, S_IMM, D_ACC, 11'd9);
        imem[1] = enc(OP_SAV, S_IMM, D_ACC, 11'd0);
        imem[2] = enc(OP_MOV, S_IMM, D_ACC, 11'd0);
        imem[3] = enc(OP_JEZ, S_IMM, D_ACC, 11'd5);
        imem[4] = enc(OP_MOV, S_IMM, D_ACC, 11'd1);
        imem[5] = enc(OP_SWP, S_IMM, D_ACC, 11'd0);
        imem[6] = enc(OP_JLZ, S_IMM, D_ACC, 11'd2);
        imem[7] = enc(OP_JMP, S_IMM, D_ACC, 11'd12);
        prog_len = 5'd8;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step();
            check("t5_pc_seq", imem_addr, exp_pc[i]);
        end
        check("t5_acc_restored", acc, 9);
        check("t5_bak", bak, 0);

        // JGZ not taken, JNZ taken
        clear_imem();
        imem[0] = enc(OP_MOV, S_IMM, D_ACC, 11'(-3));
        imem[1] = enc(OP_JGZ, S_IMM, D_ACC, 11'd3);
        imem[2] = enc(OP_JNZ, S_IMM, D_ACC, 11'd0);
        prog_len = 5'd4;
        do_reset();
        step(); step(); check("t5_jgz_nt", imem_addr, 2);
        step(); check("t5_jnz_t", imem_addr, 0);

        // JRO clamping at both ends
        clear_imem();
        imem[0] = enc(OP_JRO, S_IMM, D_ACC, 11'd20);
        imem[2] = enc(OP_JRO, S_IMM, D_ACC, 11'(-20));
        prog_len = 5'd3;
        do_reset();
        step(); check("t5_jro_hi", imem_addr, 2);
        step(); check("t5_jro_lo", imem_addr, 0);

        // Reset during WAIT_OUT drops the pending output
        clear_imem();
        imem[1] = enc(OP_MOV, S_IMM, D_OUT, 11'd3);
        prog_len = 5'd2;
        out_ready = 1'b0;
        do_reset();
        step(); check("t6_pc", imem_addr, 1);
        step(); check("t6_ov", out_valid, 1);
        step(); step();
`ifdef TIS_CTRL_STALL_CNT_EN
        check("t6_stall_cnt", stall_cnt, 2);
`endif
        #2 reset = 1'b1;
        #1;
        check("t6_rst_ov", out_valid, 0);
        check("t6_rst_pc", imem_addr, 0);
        check("t6_rst_blocked", blocked, 0);
`ifdef TIS_CTRL_STALL_CNT_EN
        check("t6_rst_stall_cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        check("t6_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
